om_range_builder: RTL

Front-end sequencer for the overflow-monitor range buffer. It accepts range-registration events (base, size, clear) from the monitor's event source over a valid/ready handshake. It validates them, computes the inclusive last address, and issues one-cycle write or clear pulses that drive the range buffer's write-enable, first/last address and synchronous-clear inputs. It also tracks how many live ranges the buffer holds and flags wrap-around, when the oldest range is overwritten.

---
 rtl/om_range_builder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/om_range_builder.sv
// Front-end sequencer for the overflow-monitor range buffer: pairs BASE/SIZE events
// into validated inclusive ranges, issues write/clear strobes and tracks buffer occupancy.
module om_range_builder #(
    parameter int SIZE = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     evt_valid_i,
    output logic                     evt_ready_o,
    input  logic [1:0]               evt_kind_i,
    input  logic [31:0]              evt_data_i,
    output logic                     en_write_o,
    output logic [31:0]              addr_first_o,
    output logic [31:0]              addr_last_o,
    output logic                     clear_o,
    output logic [$clog2(SIZE):0]    live_cnt_o,
    output logic                     wrap_o,
    output logic                     err_seq_o,
    output logic                     err_size_o
);

    localparam int CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SIZE);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HAVE_BASE = 2'd1,
        WRITE     = 2'd2,
        CLEAR     = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [31:0]   base_r;
    logic          accept_s;
    logic          base_load_s;
    logic          addr_load_s;
    logic          err_seq_s;
    logic          err_size_s;
    logic [32:0]   sum_s;
    logic          size_bad_s;

    // Ready is a function of state alone, forced low while reset is asserted
    assign evt_ready_o = ~rst_i & ((state_r == IDLE) | (state_r == HAVE_BASE));
    assign accept_s    = evt_valid_i & evt_ready_o;

    // One extra bit so a range ending exactly at 0xFFFFFFFF is told apart from overflow
    assign sum_s      = {1'b0, base_r} + {1'b0, evt_data_i};
    assign size_bad_s = (evt_data_i == 32'd0) | (sum_s > 33'h1_0000_0000);

    // Next-state and event decode
    always_comb begin
        state_s     = state_r;
        base_load_s = 1'b0;
        addr_load_s = 1'b0;
        err_seq_s   = 1'b0;
        err_size_s  = 1'b0;
        case (state_r)
            IDLE, HAVE_BASE: begin
                if (accept_s) begin
                    case (evt_kind_i)
                        2'b00: begin
                            base_load_s = 1'b1;
                            err_seq_s   = (state_r == HAVE_BASE);
                            state_s     = HAVE_BASE;
                        end
                        2'b01: begin
                            if (state_r == IDLE) begin
                                err_seq_s = 1'b1;
                            end else if (size_bad_s) begin
                                err_size_s = 1'b1;
                                state_s    = IDLE;
                            end else begin
                                addr_load_s = 1'b1;
                                state_s     = WRITE;
                            end
                        end
                        2'b10: begin
                            state_s = CLEAR;
                        end
                        default: begin
                            err_seq_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = state_r;
                end
            end
            WRITE:   state_s = IDLE;
            CLEAR:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, strobes, address outputs and occupancy tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            base_r       <= 32'd0;
            en_write_o   <= 1'b0;
            clear_o      <= 1'b0;
            err_seq_o    <= 1'b0;
            err_size_o   <= 1'b0;
            addr_first_o <= 32'd0;
            addr_last_o  <= 32'd0;
            live_cnt_o   <= '0;
            wrap_o       <= 1'b0;
        end else begin
            state_r    <= state_s;
            en_write_o <= (state_s == WRITE);
            clear_o    <= (state_s == CLEAR);
            err_seq_o  <= err_seq_s;
            err_size_o <= err_size_s;
            if (base_load_s) begin
                base_r <= evt_data_i;
            end
            if (addr_load_s) begin
                addr_first_o <= base_r;
                addr_last_o  <= sum_s[31:0] - 32'd1;
            end
            if (state_r == WRITE) begin
                if (live_cnt_o == CNT_MAX) begin
                    wrap_o <= 1'b1;
                end else begin
                    live_cnt_o <= live_cnt_o + {{(CW-1){1'b0}}, 1'b1};
                end
            end else if (state_r == CLEAR) begin
                live_cnt_o <= '0;
                wrap_o     <= 1'b0;
            end
        end
    end

endmodule
